// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: conditions one raw push-button into clean clock-synchronous events.
// Two-flop synchroniser, saturating counter debounce on both edges, registered
// press/release strobes and a debounced held level.
// Optional auto-repeat of the press strobe while held: define KEY_AUTOREPEAT_EN.
module key_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned BUTTON_ACTIVE_LOW = 1,
  parameter int unsigned REPEAT_DELAY      = 25000000,
  parameter int unsigned REPEAT_PERIOD     = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic pressing,
  output logic releasing,
  output logic held
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  // Pin level while the key is released; sync flops reset to it so no edge is seen
  localparam logic InactiveLevel = (BUTTON_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // Reject configurations the counters cannot represent
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_PERIOD == 0 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
    $error("REPEAT_PERIOD must be in 1..REPEAT_DELAY");
  end

  typedef enum logic [1:0] {StIdle, StPressWait, StDown, StReleaseWait} state_e;

  logic [1:0]      sync_q;
  logic            s;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pressing_q, pressing_d;
  logic            releasing_q, releasing_d;
  logic            held_q, held_d;

  // Synchronise the raw pin into the clock domain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= {2{InactiveLevel}};
    end else begin
      sync_q <= {sync_q[0], button};
    end
  end

  // Normalised synced sample: 1 means pressed
  assign s = sync_q[1] ^ InactiveLevel;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RptW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RptW-1:0] RptLast   = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptReload = RptW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RptW-1:0] rpt_q, rpt_d;

  // Hold-time counter for auto-repeat; frozen outside DOWN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`endif

  // FSM state, debounce counter and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pressing_q  <= 1'b0;
      releasing_q <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pressing_q  <= pressing_d;
      releasing_q <= releasing_d;
      held_q      <= held_d;
    end
  end

  // Next-state, counter and strobe decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pressing_d  = 1'b0;
    releasing_d = 1'b0;
    held_d      = held_q;
    unique case (state_q)
      StIdle: begin
        held_d = 1'b0;
        if (s) begin
          state_d = StPressWait;
          cnt_d   = CntOne;
        end
      end
      StPressWait: begin
        if (!s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q >= CntLast) begin
          state_d    = StDown;
          cnt_d      = '0;
          pressing_d = 1'b1;
          held_d     = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StDown: begin
        held_d = 1'b1;
        if (!s) begin
          state_d = StReleaseWait;
          cnt_d   = CntOne;
        end
      end
      StReleaseWait: begin
        held_d = 1'b1;
        if (s) begin
          state_d = StDown;
          cnt_d   = '0;
        end else if (cnt_q >= CntLast) begin
          state_d     = StIdle;
          cnt_d       = '0;
          releasing_d = 1'b1;
          held_d      = 1'b0;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase

`ifdef KEY_AUTOREPEAT_EN
    rpt_d = rpt_q;
    if (state_q == StPressWait && state_d == StDown) begin
      rpt_d = '0;
    end else if (state_q == StDown) begin
      // Fires even on the cycle DOWN is left for RELEASE_WAIT
      if (rpt_q >= RptLast) begin
        pressing_d = 1'b1;
        rpt_d      = RptReload;
      end else begin
        rpt_d = rpt_q + RptW'(1);
      end
    end
`endif
  end

  assign pressing  = pressing_q;
  assign releasing = releasing_q;
  assign held      = held_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench for key_debounce_pulse (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Honours KEY_AUTOREPEAT_EN for the repeat expectations.
module tb_key_debounce_pulse;

  logic clock = 1'b0;
  logic reset;
  logic button;
  logic pressing, releasing, held;

  always #5 clock = ~clock;

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES  (4),
    .BUTTON_ACTIVE_LOW(1),
    .REPEAT_DELAY     (10),
    .REPEAT_PERIOD    (3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .button   (button),
    .pressing (pressing),
    .releasing(releasing),
    .held     (held)
  );

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  typedef struct {
    int unsigned tgt;
    logic [2:0]  exp;
    string       name;
  } vec_t;

  vec_t        sb_q[$];
  int unsigned edge_cnt = 0;
  int          vec_cnt  = 0;
  int          err_cnt  = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s @edge %0d: pressing/releasing/held got %b, expected %b",
               name, edge_cnt, act, req);
    end
  endtask

  // Monitor: pop the expectation for the edge just taken and compare
  always @(negedge clock) begin : monitor
    vec_t v;
    while (sb_q.size() > 0 && sb_q[0].tgt <= edge_cnt) begin
      v = sb_q.pop_front();
      check(v.name, {pressing, releasing, held}, v.exp);
    end
  end

  // Drive the pin for the next edge and queue the outputs expected after it
  task automatic step(input string name, input logic b, input logic p, input logic r,
                      input logic h);
    vec_t v;
    button = b;
    v.tgt  = edge_cnt + 1;
    v.exp  = {p, r, h};
    v.name = name;
    sb_q.push_back(v);
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    #1;
    vec_cnt++;
    if (sb_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
  endtask

  task automatic reset_pulse(input string name);
    drain();
    reset = 1'b1;
    #1;
    check({name, "_async"}, {pressing, releasing, held}, 3'b000);
    @(posedge clock);
    #1;
    check({name, "_during"}, {pressing, releasing, held}, 3'b000);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Auto-repeat strobe edges relative to the press vector index 0 (press at 5)
  function automatic logic rep_hit(input int i, input int last);
    return AutoRep && (i >= 15) && (i <= last) && ((i - 15) % 3 == 0);
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [6:0] pat;
    reset  = 1'b1;
    button = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", {pressing, releasing, held}, 3'b000);
    reset = 1'b0;

    // 1: released pin, nothing happens
    for (int i = 0; i < 50; i++) step("idle_high", 1'b1, 1'b0, 1'b0, 1'b0);

    // 2: clean press then clean release
    for (int i = 0; i < 50; i++)
      step("press_release", (i < 40) ? 1'b0 : 1'b1, (i == 5) || rep_hit(i, 42), i == 45,
           (i >= 5) && (i < 45));

    // 3: press bounce never reaches the count
    pat = 7'b1001000;
    for (int i = 0; i < 17; i++)
      step("press_bounce", (i < 7) ? pat[i] : 1'b1, 1'b0, 1'b0, 1'b0);

    // 4: release bounce while held, then a real release
    for (int i = 0; i < 25; i++)
      step("release_bounce", (i < 8) ? 1'b0 : (i < 10) ? 1'b1 : (i < 14) ? 1'b0 : 1'b1,
           i == 5, i == 19, (i >= 5) && (i < 19));

    // 6: long hold, auto-repeat only with the feature enabled
    for (int i = 0; i < 45; i++)
      step("long_hold", (i < 30) ? 1'b0 : 1'b1, (i == 5) || rep_hit(i, 32), i == 35,
           (i >= 5) && (i < 35));

    // 5a: reset while held, then a fresh full count
    for (int i = 0; i < 8; i++) step("pre_rst_down", 1'b0, i == 5, 1'b0, i >= 5);
    reset_pulse("rst_in_down");
    for (int i = 0; i < 10; i++) step("fresh_press_a", 1'b0, i == 5, 1'b0, i >= 5);
    for (int i = 0; i < 10; i++) step("release_a", 1'b1, 1'b0, i == 5, i < 5);

    // 5b: reset mid press-debounce discards the partial count
    for (int i = 0; i < 4; i++) step("pre_rst_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    reset_pulse("rst_in_press_wait");
    for (int i = 0; i < 10; i++) step("fresh_press_b", 1'b0, i == 5, 1'b0, i >= 5);
    for (int i = 0; i < 10; i++) step("release_b", 1'b1, 1'b0, i == 5, i < 5);

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
